// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the tic-tac-toe board: cell encoding, board size,
// the table of the eight winning lines, and the checker FSM state type.
// Used by game_state_memory, game_state_checker, game_win_eval and the
// VGA renderer.
// ---------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P_O   = 2'b01,
        P_X   = 2'b10,
        RSVD  = 2'b11
    } cell_t;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    // Cell indices of each line: rows 0-2, columns 3-5, main diag 6, anti diag 7.
    localparam logic [3:0] LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_EVAL
    } state_t;

    // Reserved code 11 counts as empty, so only 01 and 10 are real marks.
    function automatic logic is_player(input cell_t c);
        return (c == P_O) || (c == P_X);
    endfunction

endpackage

// File: rtl/game_win_eval.sv
// ---------------------------------------------------------------------------
// game_win_eval
// Purely combinational board evaluator. Finds a winning line (three equal
// O or X marks), reports the winner and line index, and flags a draw when
// nothing wins and every cell holds a mark.
// Ports:
//   board     in   9 x cell_t   board snapshot, cell 0 = top-left
//   winner    out  2            01 = O, 10 = X, 00 = none
//   win_line  out  3            index of winning line (0 when no winner)
//   draw      out  1            no winner and board full
// ---------------------------------------------------------------------------
module game_win_eval
    import game_pkg::*;
(
    input  cell_t       board [NUM_CELLS],
    output logic [1:0]  winner,
    output logic [2:0]  win_line,
    output logic        draw
);

    logic  found;
    logic  full;
    cell_t ca;
    cell_t cb;
    cell_t cc;

    always_comb begin
        winner   = 2'b00;
        win_line = 3'd0;
        found    = 1'b0;
        full     = 1'b1;
        ca       = EMPTY;
        cb       = EMPTY;
        cc       = EMPTY;
        // Walk from the highest line down so the lowest winning index is the
        // one left standing on an illegal multi-win board.
        for (int l = NUM_LINES - 1; l >= 0; l--) begin
            ca = board[LINES[l][0]];
            cb = board[LINES[l][1]];
            cc = board[LINES[l][2]];
            if (is_player(ca) && (ca == cb) && (ca == cc)) begin
                winner   = ca;
                win_line = 3'(l);
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (!is_player(board[i])) begin
                full = 1'b0;
            end
        end
        draw = !found && full;
    end

endmodule

// File: rtl/game_state_checker.sv
// ---------------------------------------------------------------------------
// game_state_checker
// Read-side client of game_state_memory. On start it scans board cells
// 0..NUM_CELLS-1, captures them into a shadow board (allowing for the memory
// read latency), evaluates all lines and registers winner / win_line / draw
// with a one-cycle done pulse.
// Ports:
//   clk       in   1   system clock, rising edge
//   rst       in   1   asynchronous active-low reset
//   start     in   1   check request, sampled only in IDLE
//   r_addr    out  4   read address to game_state_memory
//   mem_data  in   2   cell value from memory
//   busy      out  1   scan in progress
//   done      out  1   one-cycle pulse when results update
//   winner    out  2   01 = O, 10 = X, 00 = none
//   win_line  out  3   winning line index
//   draw      out  1   board full with no winner
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start, r_addr held at 0
// S_READ  | stepping r_addr through the cells, one per cycle
// S_DRAIN | r_addr held on last cell while in-flight reads land
// S_EVAL  | shadow board complete; results registered on exit
// ---------------------------------------------------------------------------
module game_state_checker
    import game_pkg::*;
#(
    parameter int READ_LAT  = 1,
    parameter int NUM_CELLS = game_pkg::NUM_CELLS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  r_addr,
    input  logic [1:0]  mem_data,
    output logic        busy,
    output logic        done,
    output logic [1:0]  winner,
    output logic [2:0]  win_line,
    output logic        draw
);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] drain_cnt;
    logic       last_addr;
    cell_t      board [game_pkg::NUM_CELLS];

    logic       cap_vld;
    logic [3:0] cap_idx;

    logic [1:0] eval_winner;
    logic [2:0] eval_line;
    logic       eval_draw;

    assign last_addr = (r_addr == 4'(NUM_CELLS - 1));

    // The address issued in READ reaches mem_data READ_LAT cycles later, so
    // the address tag is delayed by the same amount before capture.
    generate
        if (READ_LAT == 0) begin : g_no_lat
            assign cap_vld = (state == S_READ);
            assign cap_idx = r_addr;
        end else begin : g_lat
            logic [READ_LAT-1:0] vld_q;
            logic [3:0]          idx_q [READ_LAT];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld_q <= '0;
                    for (int i = 0; i < READ_LAT; i++) begin
                        idx_q[i] <= 4'd0;
                    end
                end else begin
                    vld_q[0] <= (state == S_READ);
                    idx_q[0] <= r_addr;
                    for (int i = 1; i < READ_LAT; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        idx_q[i] <= idx_q[i-1];
                    end
                end
            end

            assign cap_vld = vld_q[READ_LAT-1];
            assign cap_idx = idx_q[READ_LAT-1];
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_READ;
            S_READ:  if (last_addr) state_nxt = (READ_LAT == 0) ? S_EVAL : S_DRAIN;
            S_DRAIN: if (drain_cnt == 4'd0) state_nxt = S_EVAL;
            S_EVAL:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            r_addr    <= 4'd0;
            drain_cnt <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            winner    <= 2'b00;
            win_line  <= 3'd0;
            draw      <= 1'b0;
            for (int i = 0; i < game_pkg::NUM_CELLS; i++) begin
                board[i] <= EMPTY;
            end
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    r_addr <= 4'd0;
                    if (start) busy <= 1'b1;
                end
                S_READ: begin
                    if (!last_addr) begin
                        r_addr <= r_addr + 4'd1;
                    end else begin
                        drain_cnt <= 4'(READ_LAT - 1);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt != 4'd0) drain_cnt <= drain_cnt - 4'd1;
                end
                S_EVAL: begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    winner   <= eval_winner;
                    win_line <= eval_line;
                    draw     <= eval_draw;
                    r_addr   <= 4'd0;
                end
                default: ;
            endcase
            if (cap_vld) begin
                board[cap_idx] <= cell_t'(mem_data);
            end
        end
    end

    game_win_eval u_win_eval (
        .board    (board),
        .winner   (eval_winner),
        .win_line (eval_line),
        .draw     (eval_draw)
    );

endmodule

// File: tb/tb_game_state_checker.sv
module tb_game_state_checker;

    localparam int RL = 1;
    localparam logic [1:0] CE = 2'b00;
    localparam logic [1:0] CO = 2'b01;
    localparam logic [1:0] CX = 2'b10;
    localparam logic [1:0] CR = 2'b11;
    localparam int DONE_N = 10 + RL;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] r_addr;
    logic [1:0] mem_data = 2'b00;
    logic       busy;
    logic       done;
    logic [1:0] winner;
    logic [2:0] win_line;
    logic       draw;

    logic [1:0] mem [9];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    // Registered-read memory model, one cycle of latency to match RL.
    always @(posedge clk) mem_data <= (r_addr < 4'd9) ? mem[r_addr] : 2'b00;

    game_state_checker #(.READ_LAT(RL), .NUM_CELLS(9)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .r_addr   (r_addr),
        .mem_data (mem_data),
        .busy     (busy),
        .done     (done),
        .winner   (winner),
        .win_line (win_line),
        .draw     (draw)
    );

    task automatic load_board(input logic [1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
        mem[0] = c0; mem[1] = c1; mem[2] = c2;
        mem[3] = c3; mem[4] = c4; mem[5] = c5;
        mem[6] = c6; mem[7] = c7; mem[8] = c8;
    endtask

    // Returns at #1 after the edge that accepts start (E0).
    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after E0 until done is seen; 40 means it never came.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 40);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (r_addr !== 4'd0) begin errors++; $display("FAIL reset_r_addr got %0d exp 0", r_addr); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        vectors++; if (winner !== 2'b00) begin errors++; $display("FAIL reset_winner got %0b exp 00", winner); end
        vectors++; if (win_line !== 3'd0) begin errors++; $display("FAIL reset_win_line got %0d exp 0", win_line); end
        vectors++; if (draw !== 1'b0) begin errors++; $display("FAIL reset_draw got %0b exp 0", draw); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_empty();
        int n;
        load_board(CE, CE, CE, CE, CE, CE, CE, CE, CE);
        launch();
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL empty_busy_after_start got %0b exp 1", busy); end
        wait_done(n);
        vectors++; if (n !== DONE_N) begin errors++; $display("FAIL empty_done_latency got %0d exp %0d", n, DONE_N); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy_at_done got %0b exp 0", busy); end
        vectors++; if (winner !== 2'b00) begin errors++; $display("FAIL empty_winner got %0b exp 00", winner); end
        vectors++; if (draw !== 1'b0) begin errors++; $display("FAIL empty_draw got %0b exp 0", draw); end
    endtask

    task automatic test_row_x();
        int n;
        load_board(CX, CX, CX, CO, CO, CE, CE, CE, CE);
        launch();
        wait_done(n);
        vectors++; if (n !== DONE_N) begin errors++; $display("FAIL row_x_latency got %0d exp %0d", n, DONE_N); end
        vectors++; if (winner !== 2'b10) begin errors++; $display("FAIL row_x_winner got %0b exp 10", winner); end
        vectors++; if (win_line !== 3'd0) begin errors++; $display("FAIL row_x_line got %0d exp 0", win_line); end
        vectors++; if (draw !== 1'b0) begin errors++; $display("FAIL row_x_draw got %0b exp 0", draw); end
        @(posedge clk);
        #1;
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL row_x_done_one_cycle got %0b exp 0", done); end
        vectors++; if (winner !== 2'b10) begin errors++; $display("FAIL row_x_winner_hold got %0b exp 10", winner); end
    endtask

    task automatic test_anti_diag_o();
        int n;
        load_board(CX, CX, CO, CE, CO, CE, CO, CE, CE);
        launch();
        wait_done(n);
        vectors++; if (winner !== 2'b01) begin errors++; $display("FAIL anti_diag_winner got %0b exp 01", winner); end
        vectors++; if (win_line !== 3'd7) begin errors++; $display("FAIL anti_diag_line got %0d exp 7", win_line); end
        vectors++; if (draw !== 1'b0) begin errors++; $display("FAIL anti_diag_draw got %0b exp 0", draw); end
    endtask

    task automatic test_draw();
        int n;
        load_board(CX, CO, CX, CX, CO, CO, CO, CX, CX);
        launch();
        wait_done(n);
        vectors++; if (winner !== 2'b00) begin errors++; $display("FAIL draw_winner got %0b exp 00", winner); end
        vectors++; if (win_line !== 3'd0) begin errors++; $display("FAIL draw_line got %0d exp 0", win_line); end
        vectors++; if (draw !== 1'b1) begin errors++; $display("FAIL draw_flag got %0b exp 1", draw); end
    endtask

    task automatic test_reserved();
        int n;
        load_board(CR, CR, CR, CE, CE, CE, CE, CE, CE);
        launch();
        wait_done(n);
        vectors++; if (winner !== 2'b00) begin errors++; $display("FAIL rsvd_row_winner got %0b exp 00", winner); end
        vectors++; if (draw !== 1'b0) begin errors++; $display("FAIL rsvd_row_draw got %0b exp 0", draw); end
        load_board(CX, CO, CX, CX, CO, CO, CO, CX, CR);
        launch();
        wait_done(n);
        vectors++; if (winner !== 2'b00) begin errors++; $display("FAIL rsvd_full_winner got %0b exp 00", winner); end
        vectors++; if (draw !== 1'b0) begin errors++; $display("FAIL rsvd_full_draw got %0b exp 0", draw); end
    endtask

    task automatic test_lines();
        int n;
        // Column 1 of X -> line 4.
        load_board(CO, CX, CE, CE, CX, CO, CE, CX, CE);
        launch();
        wait_done(n);
        vectors++; if (winner !== 2'b10) begin errors++; $display("FAIL col1_winner got %0b exp 10", winner); end
        vectors++; if (win_line !== 3'd4) begin errors++; $display("FAIL col1_line got %0d exp 4", win_line); end
        // Main diagonal of O -> line 6.
        load_board(CO, CX, CX, CE, CO, CE, CE, CE, CO);
        launch();
        wait_done(n);
        vectors++; if (winner !== 2'b01) begin errors++; $display("FAIL diag_winner got %0b exp 01", winner); end
        vectors++; if (win_line !== 3'd6) begin errors++; $display("FAIL diag_line got %0d exp 6", win_line); end
    endtask

    task automatic test_illegal_two_rows();
        int n;
        load_board(CO, CO, CO, CX, CX, CX, CE, CE, CE);
        launch();
        wait_done(n);
        vectors++; if (winner !== 2'b01) begin errors++; $display("FAIL two_rows_winner got %0b exp 01", winner); end
        vectors++; if (win_line !== 3'd0) begin errors++; $display("FAIL two_rows_line got %0d exp 0", win_line); end
    endtask

    task automatic test_reset_mid_scan();
        int n;
        int k;
        load_board(CO, CO, CX, CX, CX, CE, CE, CE, CE);
        launch();
        k = 0;
        while (r_addr !== 4'd4 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        vectors++; if (r_addr !== 4'd4) begin errors++; $display("FAIL midscan_reach_addr4 got %0d exp 4", r_addr); end
        rst = 1'b0;
        #1;
        vectors++; if (r_addr !== 4'd0) begin errors++; $display("FAIL midscan_rst_r_addr got %0d exp 0", r_addr); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL midscan_rst_busy got %0b exp 0", busy); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL midscan_rst_done got %0b exp 0", done); end
        vectors++; if (winner !== 2'b00) begin errors++; $display("FAIL midscan_rst_winner got %0b exp 00", winner); end
        vectors++; if (win_line !== 3'd0) begin errors++; $display("FAIL midscan_rst_line got %0d exp 0", win_line); end
        vectors++; if (draw !== 1'b0) begin errors++; $display("FAIL midscan_rst_draw got %0b exp 0", draw); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        load_board(CX, CE, CX, CE, CX, CE, CO, CO, CO);
        launch();
        wait_done(n);
        vectors++; if (n !== DONE_N) begin errors++; $display("FAIL midscan_rescan_latency got %0d exp %0d", n, DONE_N); end
        vectors++; if (winner !== 2'b01) begin errors++; $display("FAIL midscan_rescan_winner got %0b exp 01", winner); end
        vectors++; if (win_line !== 3'd2) begin errors++; $display("FAIL midscan_rescan_line got %0d exp 2", win_line); end
    endtask

    task automatic test_start_while_busy();
        int ndone;
        int done_at;
        ndone   = 0;
        done_at = 0;
        load_board(CE, CE, CX, CE, CE, CX, CO, CO, CX);
        launch();
        // start held high for the edges E2..E11, including the done edge.
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = (c >= 2 && c <= DONE_N);
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                done_at = c;
            end
            if (c == 5) begin
                vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid_scan got %0b exp 1", busy); end
            end
        end
        start = 1'b0;
        vectors++; if (ndone !== 1) begin errors++; $display("FAIL busy_start_done_count got %0d exp 1", ndone); end
        vectors++; if (done_at !== DONE_N) begin errors++; $display("FAIL busy_start_done_edge got %0d exp %0d", done_at, DONE_N); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got %0b exp 0", busy); end
        vectors++; if (winner !== 2'b10) begin errors++; $display("FAIL busy_start_winner got %0b exp 10", winner); end
        vectors++; if (win_line !== 3'd5) begin errors++; $display("FAIL busy_start_line got %0d exp 5", win_line); end
    endtask

    task automatic test_back_to_back();
        int n;
        load_board(CX, CO, CE, CE, CE, CE, CE, CE, CE);
        launch();
        wait_done(n);
        vectors++; if (winner !== 2'b00) begin errors++; $display("FAIL b2b_first_winner got %0b exp 00", winner); end
        // Next start sampled at the first IDLE edge, one cycle after done.
        load_board(CO, CX, CE, CO, CX, CE, CO, CE, CE);
        launch();
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %0b exp 1", busy); end
        wait_done(n);
        vectors++; if (n !== DONE_N) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", n, DONE_N); end
        vectors++; if (winner !== 2'b01) begin errors++; $display("FAIL b2b_winner got %0b exp 01", winner); end
        vectors++; if (win_line !== 3'd3) begin errors++; $display("FAIL b2b_line got %0d exp 3", win_line); end
    endtask

    initial begin
        load_board(CE, CE, CE, CE, CE, CE, CE, CE, CE);
        test_reset();
        test_empty();
        test_row_x();
        test_draw();
        test_reserved();
        test_lines();
        test_illegal_two_rows();
        test_anti_diag_o();
        test_reset_mid_scan();
        test_start_while_busy();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
